// File: rtl/data_cache.sv
// data_cache -- direct-mapped, write-back, write-allocate data cache.
//
// Serves CPU word loads/stores in the same cycle on a hit. On a miss it stalls
// the CPU, writes back a dirty victim one word at a time, then refills the
// line one word at a time using the memory read/write/busywait handshake.
//
// Optional feature macro: DCACHE_STATS_EN (saturating hit/miss counters).
// When it is undefined, hit_count/miss_count are tied to zero.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   cpu_read/cpu_write      load/store request, held while cpu_busywait is high
//   cpu_address[7:0]        byte address (bits [1:0] ignored)
//   cpu_writedata[31:0]     store data
//   cpu_readdata[31:0]      load data, combinational from the array
//   cpu_busywait            stall to the pipeline
//   mem_read/mem_write      memory requests (never both high)
//   mem_address[5:0]        word address to memory
//   mem_writedata[31:0]     write-back word
//   mem_readdata[31:0]      refill word
//   mem_busywait            memory busy
//   hit_count/miss_count    statistics
module data_cache #(
   parameter int INDEX_BITS  = 3,
   parameter int OFFSET_BITS = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpu_read,
   input  logic        cpu_write,
   input  logic [7:0]  cpu_address,
   input  logic [31:0] cpu_writedata,
   output logic [31:0] cpu_readdata,
   output logic        cpu_busywait,
   output logic        mem_read,
   output logic        mem_write,
   output logic [5:0]  mem_address,
   output logic [31:0] mem_writedata,
   input  logic [31:0] mem_readdata,
   input  logic        mem_busywait,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
);
   localparam int TAG_BITS = 6 - INDEX_BITS - OFFSET_BITS;
   localparam int LINES    = 1 << INDEX_BITS;
   localparam int WORDS    = 1 << OFFSET_BITS;

   typedef enum logic [2:0] {S_IDLE, S_WB, S_WB_GAP, S_FETCH, S_FETCH_GAP} state_t;

   state_t                 r_state, w_next_state;
   logic [OFFSET_BITS-1:0] r_word_cnt;
   logic                   r_seen_busy;
   logic [LINES-1:0]       r_valid, r_dirty;
   logic [TAG_BITS-1:0]    r_tag  [LINES];
   logic [31:0]            r_data [LINES][WORDS];

   logic [OFFSET_BITS-1:0] w_offset;
   logic [INDEX_BITS-1:0]  w_index;
   logic [TAG_BITS-1:0]    w_tag;
   logic                   w_req, w_is_write, w_hit, w_mem_phase, w_done, w_last_word;
   logic                   w_unused_addr;

   assign w_offset      = cpu_address[2 +: OFFSET_BITS];
   assign w_index       = cpu_address[2 + OFFSET_BITS +: INDEX_BITS];
   assign w_tag         = cpu_address[7 -: TAG_BITS];
   assign w_unused_addr = ^cpu_address[1:0];

   // Read and write together is a read.
   assign w_req       = cpu_read | cpu_write;
   assign w_is_write  = cpu_write & ~cpu_read;
   assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign w_mem_phase = (r_state == S_WB) || (r_state == S_FETCH);
   // A word finishes only once busywait has been seen high and then low,
   // so a stale low busywait at request start is not taken as completion.
   assign w_done      = w_mem_phase && r_seen_busy && !mem_busywait;
   assign w_last_word = (r_word_cnt == '1);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:      if (w_req && !w_hit)
                         w_next_state = (r_valid[w_index] && r_dirty[w_index]) ? S_WB : S_FETCH;
         S_WB:        if (w_done) w_next_state = S_WB_GAP;
         // word_cnt has wrapped to 0 after the last victim word
         S_WB_GAP:    w_next_state = (r_word_cnt != '0) ? S_WB : S_FETCH;
         S_FETCH:     if (w_done) w_next_state = S_FETCH_GAP;
         S_FETCH_GAP: w_next_state = (r_word_cnt != '0) ? S_FETCH : S_IDLE;
         default:     w_next_state = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_address   = '0;
      mem_writedata = '0;
      cpu_busywait  = 1'b1;
      case (r_state)
         S_IDLE:  cpu_busywait = w_req && !w_hit;
         S_WB: begin
            mem_write     = 1'b1;
            mem_address   = {r_tag[w_index], w_index, r_word_cnt};
            mem_writedata = r_data[w_index][r_word_cnt];
         end
         S_FETCH: begin
            mem_read    = 1'b1;
            mem_address = {w_tag, w_index, r_word_cnt};
         end
         default: ;
      endcase
   end

   assign cpu_readdata = r_data[w_index][w_offset];

   // ---------------- word counter / handshake tracking ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_word_cnt  <= '0;
         r_seen_busy <= 1'b0;
      end else begin
         if (r_state == S_IDLE) r_word_cnt <= '0;
         else if (w_done)       r_word_cnt <= r_word_cnt + 1'b1;

         if (!w_mem_phase || w_done) r_seen_busy <= 1'b0;
         else if (mem_busywait)      r_seen_busy <= 1'b1;
      end
   end

   // ---------------- line status ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (r_state == S_IDLE && w_is_write && w_hit) begin
         r_dirty[w_index] <= 1'b1;
      end else if (r_state == S_FETCH && w_done && w_last_word) begin
         r_valid[w_index] <= 1'b1;
         r_dirty[w_index] <= 1'b0;
      end
   end

   // Data and tags carry no reset; valid gates their use.
   always_ff @(posedge clock) begin
      if (r_state == S_IDLE && w_is_write && w_hit)
         r_data[w_index][w_offset] <= cpu_writedata;
      if (r_state == S_FETCH && w_done) begin
         r_data[w_index][r_word_cnt] <= mem_readdata;
         if (w_last_word) r_tag[w_index] <= w_tag;
      end
   end

   // ---------------- statistics ----------------
`ifdef DCACHE_STATS_EN
   logic [15:0] r_hit_count, r_miss_count;
   logic        r_after_fill;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
         r_after_fill <= 1'b0;
      end else begin
         if (r_state == S_IDLE && w_req && !w_hit && r_miss_count != 16'hFFFF)
            r_miss_count <= r_miss_count + 16'd1;
         // The held request that triggered a refill is already counted as a miss.
         if (r_state == S_IDLE && w_req && w_hit && !r_after_fill && r_hit_count != 16'hFFFF)
            r_hit_count <= r_hit_count + 16'd1;
         if (r_state == S_FETCH_GAP && w_next_state == S_IDLE) r_after_fill <= 1'b1;
         else if (r_state == S_IDLE && w_req)                 r_after_fill <= 1'b0;
      end
   end

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM stage and `data_memory`. It serves word loads and stores from the CPU in the same cycle on a hit. On a miss it stalls the CPU with `cpu_busywait`, writes back a dirty victim line one word at a time, then refills the line one word at a time over the memory's read/write/busywait handshake.

## Interface
- `INDEX_BITS`, 3: line index width; 8 lines.
- `OFFSET_BITS`, 2: word-in-line width; 4 words (16 B) per line.
- Derived `TAG_BITS` = 6 − `INDEX_BITS` − `OFFSET_BITS` = 1. The word address is 6 bits, matching the memory.
- `clock` in 1: clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `cpu_read` in 1: load request, held until `cpu_busywait` is low.
- `cpu_write` in 1: store request, held until `cpu_busywait` is low.
- `cpu_address` in 8: byte address. Bits [1:0] are ignored; word = [7:2], offset = [3:2], index = [6:4], tag = [7].
- `cpu_writedata` in 32: store data.
- `cpu_readdata` out 32: load data, combinational from the array.
- `cpu_busywait` out 1: stall to the pipeline.
- `mem_read`, `mem_write` out 1: memory requests, never both high.
- `mem_address` out 6: word address to memory.
- `mem_writedata` out 32: write-back word.
- `mem_readdata` in 32: refill word.
- `mem_busywait` in 1: memory busy.
- `hit_count`, `miss_count` out 16: statistics; see Configuration.

## Operation
- Storage per line: valid, dirty, tag, and 4×32 data. Reset clears every valid and dirty bit; data is undefined.
- Hit = valid[index] && tag[index] == addr tag.
- FSM states: IDLE, WB, WB_GAP, FETCH, FETCH_GAP. Counter `word_cnt`[1:0].
- **IDLE, read hit:** `cpu_readdata` = line word at offset; `cpu_busywait` = 0.
- **IDLE, write hit:** the word is written and dirty is set at the clock edge; `cpu_busywait` = 0.
- **IDLE, miss:** `cpu_busywait` = 1 combinationally. At the clock edge, go to WB if valid && dirty, else go to FETCH. `word_cnt` = 0.
- **WB:**
  - `mem_write` = 1.
  - `mem_address` = {stored tag, index, `word_cnt`}.
  - `mem_writedata` = stored word[`word_cnt`].
  - Word complete at the first edge where `mem_busywait` is sampled 0 after being sampled 1 in this state.
  - On completion go to WB_GAP, with `word_cnt`+1 wrapping.
- **WB_GAP:**
  - Requests are low for exactly one cycle, so the memory detects a fresh request.
  - Go to WB if `word_cnt` ≠ 0, else go to FETCH with `word_cnt` = 0.
- **FETCH:**
  - `mem_read` = 1.
  - `mem_address` = {cpu tag, index, `word_cnt`}.
  - Completion rule is the same as WB; `mem_readdata` is written to word[`word_cnt`].
  - After word 3: set valid, tag = cpu tag, clear dirty, then go to FETCH_GAP.
- **FETCH_GAP:**
  - Go to FETCH if words remain, else go to IDLE.
  - The held CPU request then hits and completes through the normal hit path; a store sets dirty there.
- `cpu_busywait` = 1 in every non-IDLE state.
- `cpu_read` && `cpu_write` together is treated as a read.

## Timing
- Reset values: FSM IDLE, `word_cnt` 0, `mem_read`/`mem_write` 0, `mem_address` 0, `mem_writedata` 0, counters 0. `cpu_busywait` 0 when there is no request.
- Reset asserted mid-refill or mid-write-back: immediately return to IDLE, requests drop, valid cleared. A partially written-back victim is lost.
- Hit latency is 0 cycles: data is valid the same cycle and the store commits at the next edge.
- Miss penalty = (dirty ? 4 : 0) word writes + 4 word reads. Each word costs its memory busy time plus 1 gap cycle, plus 1 IDLE cycle for the hit.
- `mem_address` and `mem_writedata` are stable for the whole time a request is high.
- CPU inputs are ignored outside IDLE. The pipeline holds them stable while `cpu_busywait` is high.

## Configuration
- `DCACHE_STATS_EN` defined:
  - `miss_count` increments on every IDLE→WB or IDLE→FETCH transition.
  - `hit_count` increments on every IDLE-state hit access, except the first access after a refill completes.
  - Both counters saturate at 16'hFFFF and clear on reset.
- `DCACHE_STATS_EN` undefined: both outputs tied to 0; no counter logic.

## Test plan
- Reset, then read 0x00 → `cpu_busywait` high; 4 `mem_read` at words 0,1,2,3, each preceded by a low gap cycle; then `cpu_readdata` = memory word 0 and busywait drops. With stats: `miss_count` = 1, `hit_count` = 0.
- Immediately read 0x0C → hit, 0-cycle latency, returns memory word 3, no `mem_read`.
- Write 0xDEADBEEF to 0x04 (line resident) → no memory traffic; a following read of 0x04 returns 0xDEADBEEF.
- Read 0x84 (same index 0, tag 1) → 4 `mem_write` to words 0–3 carrying the dirty line (word 1 = 0xDEADBEEF), then 4 `mem_read` of words 0x20–0x23.
- Read 0x84 again with a clean line evicted by 0x04 → fetch only, no `mem_write`.
- Assert `reset` during the second FETCH word → `mem_read` drops asynchronously, FSM IDLE; next read of 0x84 misses.
